fifo_pop_adapter: RTL and testbench
===================================

FIFO_POP_ADAPTER -- requirements
Module: fifo_pop_adapter

Interface
REQ-001 SHALL have parameter W, default 32, data width in bits.
REQ-002 SHALL have parameter D, default 2, skid-buffer depth in entries; power of 2, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port empty_r  input  1  FIFO empty flag (registered, accurate the cycle after a pop).
REQ-006 SHALL have port pop  output  1  pop request to FIFO.
REQ-007 SHALL have port pop_data  input  W  FIFO read data, valid when pop_data_vld_r=1.
REQ-008 SHALL have port pop_data_vld_r  input  1  FIFO read-data valid, exactly one cycle after pop.
REQ-009 SHALL have port out_vld  output  1  output stream valid.
REQ-010 SHALL have port out_data  output  W  output stream data.
REQ-011 SHALL have port out_rdy  input  1  output stream ready; transfer when out_vld & out_rdy.
REQ-012 SHALL have port stall_cnt_r  output  16  output-stall cycle count (see Configuration).

Function
REQ-013 SHALL hold a D-entry circular buffer; rd/wr pointers log2(D)+1 bits, MSB as wrap bit; empty = pointers equal; full = MSBs differ, low bits equal.
REQ-014 SHALL track pend_r = pop registered (one read in flight); pend_r is 0 or 1.
REQ-015 SHALL drive pop = ~rst & ~empty_r & ((count + pend_r - deq) < D), where count = buffer occupancy and deq = out_vld & out_rdy.
REQ-016 SHALL enqueue pop_data at wr pointer when pop_data_vld_r=1, advance wr pointer same edge.
REQ-017 SHALL drive out_vld = (count != 0), out_data = entry at rd pointer; both from flops only, no combinational path from out_rdy or pop_data.
REQ-018 SHALL advance rd pointer on deq; simultaneous enqueue and deq leaves count unchanged.
REQ-019 SHALL sustain one transfer per cycle with D=2 when empty_r=0 and out_rdy=1 continuously, after 2-cycle fill latency (pop at t, out_vld at t+2).
REQ-020 SHALL deliver data in FIFO pop order, never drop or duplicate an entry.
REQ-021 SHALL never cause overflow: pop_data_vld_r=1 with buffer full is a protocol error, flagged by assertion.
REQ-022 SHALL flag by assertion pop_data_vld_r=1 when pend_r=0, and pop=1 while empty_r=1.
REQ-023 SHALL hold out_data stable while out_vld=1 and out_rdy=0.
REQ-024 SHALL wrap pointers modulo 2*D without special handling.

Reset
REQ-025 SHALL, on any cycle with rst=1, set next state: pointers 0, count 0, pend_r 0, stall_cnt_r 0.
REQ-026 SHALL output pop=0 during rst, out_vld=0 the cycle after rst asserted.
REQ-027 SHALL ignore pop_data_vld_r during rst cycles (data returning from a pre-reset pop is discarded).
REQ-028 SHALL allow rst assertion mid-transfer; first pop no earlier than the first cycle with rst=0.

Configuration
REQ-029 SHALL compile the stall counter only when macro FIFO_POP_ADAPTER_STALL_CNT_EN is defined.
REQ-030 SHALL, with FIFO_POP_ADAPTER_STALL_CNT_EN defined, increment stall_cnt_r each cycle out_vld=1 & out_rdy=0, saturating at 16'hFFFF.
REQ-031 SHALL, without FIFO_POP_ADAPTER_STALL_CNT_EN, tie stall_cnt_r to 0 with no counter flops; all other behaviour identical.

Verification
REQ-032 SHALL cover streaming: empty_r=0, out_rdy=1, FIFO data 0x10..0x1F (16 words) -> out_data 0x10..0x1F in order, one per cycle from cycle 2 after first pop.
REQ-033 SHALL cover backpressure: out_rdy=0 for 10 cycles, D=2 -> exactly 2 pops issued, out_data holds first word, then 0 loss on out_rdy=1.
REQ-034 SHALL cover source empty: empty_r=1 after 3 words -> pop=0, out_vld drops after 3 transfers, resumes when empty_r=0.
REQ-035 SHALL cover pointer wrap: D=4, 100 words random out_rdy (50%) -> scoreboard exact order match, no overflow assertion.
REQ-036 SHALL cover reset mid-operation: rst=1 for 1 cycle with 2 entries buffered and 1 in flight -> out_vld=0 next cycle, in-flight word discarded, pop=0 during rst.
REQ-037 SHALL cover stall counter: macro defined, 5 stall cycles -> stall_cnt_r=5; macro undefined -> stall_cnt_r=0.

Source files
------------

// File: rtl/fifo_pop_adapter.sv
// Converts a registered-read FIFO pop interface into a valid/ready stream via a D-entry skid buffer.
// Optional output-stall counter is compiled in only when FIFO_POP_ADAPTER_STALL_CNT_EN is defined.
module fifo_pop_adapter #(
  parameter int W = 32,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         empty_r,
  output logic         pop,
  input  logic [W-1:0] pop_data,
  input  logic         pop_data_vld_r,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  input  logic         out_rdy,
  output logic [15:0]  stall_cnt_r
);

  localparam int AW = $clog2(D);
  localparam logic [AW+1:0] DEPTH = (AW+2)'(D);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          pend_q, pend_d;
  logic [W-1:0]  mem_q [D];
  logic [AW:0]   count;
  logic [AW+1:0] proj;
  logic          full;
  logic          deq;
  logic          enq;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign out_vld  = (count != '0);
  assign out_data = mem_q[rd_ptr_q[AW-1:0]];
  assign deq      = out_vld & out_rdy;
  // Returning data during reset belongs to a pre-reset pop and is dropped.
  assign enq      = pop_data_vld_r & ~rst & ~full;

  // Occupancy after this edge, counting the read in flight, must leave room for one more.
  assign proj = {1'b0, count} + {{(AW+1){1'b0}}, pend_q} - {{(AW+1){1'b0}}, deq};
  assign pop  = ~rst & ~empty_r & (proj < DEPTH);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pend_d   = pop;
    if (enq) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (deq) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    pend_q   <= pend_d;
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= pop_data;
  end

`ifdef FIFO_POP_ADAPTER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_vld && !out_rdy && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (rst) stall_cnt_d = 16'h0;
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_r = stall_cnt_q;
`else
  assign stall_cnt_r = 16'h0;
`endif

  // Source protocol checks; reset cycles are exempt since in-flight data is legal there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_overflow: assert (!(pop_data_vld_r && full))
        else $error("fifo_pop_adapter: read data returned while buffer full");
      a_vld_needs_pend: assert (!(pop_data_vld_r && !pend_q))
        else $error("fifo_pop_adapter: read data without outstanding pop");
      a_no_pop_empty: assert (!(pop && empty_r))
        else $error("fifo_pop_adapter: pop issued while source empty");
    end
  end

endmodule

// File: tb/tb_fifo_pop_adapter.sv
// Directed bench for fifo_pop_adapter: lane 0 uses D=2, lane 1 uses D=4.
// Each lane has a small registered-read FIFO model supplying data base + index.
module tb_fifo_pop_adapter;

  logic        clk;
  logic        rst;
  logic        empty_r        [2];
  logic        pop            [2];
  logic [31:0] pop_data       [2];
  logic        pop_data_vld_r [2];
  logic        out_vld        [2];
  logic [31:0] out_data       [2];
  logic        out_rdy        [2];
  logic [15:0] stall_cnt_r    [2];

  logic        src_clr [2];
  int          avail   [2];
  logic [31:0] base    [2];
  int          rd_i    [2];
  int          nxt;

  int n_chk;
  int n_bad;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int DEP = (g == 0) ? 2 : 4;
    fifo_pop_adapter #(.W(32), .D(DEP)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .empty_r        (empty_r[g]),
      .pop            (pop[g]),
      .pop_data       (pop_data[g]),
      .pop_data_vld_r (pop_data_vld_r[g]),
      .out_vld        (out_vld[g]),
      .out_data       (out_data[g]),
      .out_rdy        (out_rdy[g]),
      .stall_cnt_r    (stall_cnt_r[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO: read data one cycle after pop, empty flag registered.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      nxt = src_clr[g] ? 0 : rd_i[g] + (pop[g] ? 1 : 0);
      pop_data_vld_r[g] <= pop[g];
      if (pop[g]) pop_data[g] <= base[g] + rd_i[g];
      rd_i[g]    <= nxt;
      empty_r[g] <= (nxt >= avail[g]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int av0, input int av1, input logic [31:0] b0, input logic [31:0] b1);
    @(negedge clk);
    rst = 1'b1;
    src_clr[0] = 1'b1; src_clr[1] = 1'b1;
    avail[0] = av0;    avail[1] = av1;
    base[0] = b0;      base[1] = b1;
    out_rdy[0] = 1'b0; out_rdy[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    src_clr[0] = 1'b0; src_clr[1] = 1'b0;
    #1;
  endtask

  // Accept with out_rdy=1 until n words are taken, checking order against first+i.
  task automatic drain(input string tag, input int ln, input int n, input logic [31:0] first, input int bound);
    int got;
    got = 0;
    out_rdy[ln] = 1'b1;
    for (int c = 0; c < bound && got < n; c++) begin
      if (out_vld[ln]) begin
        chk(tag, out_data[ln], first + got);
        got++;
      end
      @(negedge clk);
    end
    chk({tag, "_cnt"}, got, n);
  endtask

  initial begin
    int npop;
    int n;
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      src_clr[g] = 1'b1;
      avail[g]   = 0;
      base[g]    = '0;
      out_rdy[g] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_vld0", out_vld[0], 0);
    chk("rst_vld1", out_vld[1], 0);
    chk("rst_pop0", pop[0], 0);
    chk("rst_stall", stall_cnt_r[0], 0);

    // Streaming: 0x10..0x1F, one per cycle, out_vld two cycles after first pop
    do_reset(16, 0, 32'h10, 0);
    out_rdy[0] = 1'b1;
    chk("strm_pop0", pop[0], 1);
    @(negedge clk);
    chk("strm_lat", out_vld[0], 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("strm_vld", out_vld[0], 1);
      chk("strm_data", out_data[0], 32'h10 + k);
    end
    @(negedge clk);
    chk("strm_end", out_vld[0], 0);

    // Backpressure: 10 stalled cycles admit exactly 2 pops, head held, no loss
    do_reset(8, 0, 32'h40, 0);
    npop = 0;
    for (int i = 0; i < 10; i++) begin
      if (pop[0]) npop++;
      @(negedge clk);
    end
    chk("bp_pops", npop, 2);
    chk("bp_vld", out_vld[0], 1);
    chk("bp_hold", out_data[0], 32'h40);
    drain("bp_data", 0, 8, 32'h40, 60);

    // Source empty after 3 words, then resume
    do_reset(3, 0, 32'h60, 0);
    drain("emp_data", 0, 3, 32'h60, 20);
    for (int i = 0; i < 4; i++) begin
      chk("emp_pop", pop[0], 0);
      chk("emp_vld", out_vld[0], 0);
      @(negedge clk);
    end
    avail[0] = 6;
    drain("emp_resume", 0, 3, 32'h63, 20);

    // Stall counter: 5 stalled cycles
    do_reset(1, 0, 32'h20, 0);
    chk("stl_clr", stall_cnt_r[0], 0);
    @(negedge clk);
    @(negedge clk);
    chk("stl_vld", out_vld[0], 1);
    repeat (5) @(negedge clk);
`ifdef FIFO_POP_ADAPTER_STALL_CNT_EN
    chk("stl_cnt", stall_cnt_r[0], 5);
`else
    chk("stl_cnt", stall_cnt_r[0], 0);
`endif
    drain("stl_data", 0, 1, 32'h20, 10);

    // Reset mid-operation on D=4: 2 buffered, 1 in flight (0x82) is discarded
    do_reset(0, 8, 0, 32'h80);
    repeat (3) @(negedge clk);
    chk("mrst_pre_vld", out_vld[1], 1);
    chk("mrst_pre_data", out_data[1], 32'h80);
    rst = 1'b1;
    #1;
    chk("mrst_pop", pop[1], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_vld", out_vld[1], 0);
    drain("mrst_data", 1, 5, 32'h83, 40);

    // Pointer wrap on D=4 with random ready
    do_reset(0, 100, 0, 32'h1000);
    n = 0;
    for (int c = 0; c < 3000 && n < 100; c++) begin
      out_rdy[1] = 1'($urandom_range(0, 1));
      if (out_vld[1] && out_rdy[1]) begin
        chk("wrap_data", out_data[1], 32'h1000 + n);
        n++;
      end
      @(negedge clk);
    end
    chk("wrap_cnt", n, 100);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
